systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream operand stage for the output-stationary systolic array.
- Accepts one K-slice per beat over a valid/ready handshake: an activation column (one element per array row) and a weight row (one element per array column).
- Applies the diagonal skew (row i delayed i cycles, column j delayed j cycles), drives the array's clear, zero-fills bubbles and the drain, and pulses done_o when every PE holds its final dot product.

Parameters:
- DATA_WIDTH, 32: width of each activation/weight element; equals the array's PE input width.
- ARRAY_WIDTH, 4: array columns; number of weight lanes.
- ARRAY_HEIGHT, 4: array rows; number of activation lanes.
- K_MAX, 64: maximum reduction length per job.
- K_WIDTH, $clog2(K_MAX+1): width of k_len_i.
- PE_LAT, 1: cycles from a PE input to its accumulator update becoming visible.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  job start request, sampled only in IDLE
- k_len_i  input  K_WIDTH  reduction length, latched with start_i
- busy_o  output  1  high in every state except IDLE
- err_o  output  1  one-cycle pulse when start_i carries an illegal k_len_i
- in_vld_i  input  1  operand beat valid
- in_rdy_o  output  1  operand beat ready
- act_col_i  input  DATA_WIDTH x ARRAY_HEIGHT  activation element k for rows 0..H-1
- wgt_row_i  input  DATA_WIDTH x ARRAY_WIDTH  weight element k for columns 0..W-1
- clear_o  output  1  connects to the array's ctrl_start_i (accumulator clear)
- active_o  output  DATA_WIDTH x ARRAY_HEIGHT  skewed activations into the array's left edge
- weight_o  output  DATA_WIDTH x ARRAY_WIDTH  skewed weights into the array's top edge
- done_o  output  1  one-cycle pulse: array results are final and stable

Behaviour:
- Reset is asynchronous and active-high. On reset: state IDLE; all skew registers 0; active_o, weight_o = 0; clear_o, in_rdy_o, busy_o, done_o, err_o = 0; beat and drain counters 0. Reset mid-job abandons the job; no done_o is produced.
- Skew lanes: activation lane i is a register chain of depth i+1; weight lane j has depth j+1. All outputs are registered. All chains shift every cycle in every state.
  - Lane head loads the beat data when in_vld_i && in_rdy_o; otherwise it loads 0.
  - Consequence: an element accepted at edge t appears on active_o[i] in cycle t+1+i and on weight_o[j] in cycle t+1+j.
  - Bubbles inject zeros on all lanes simultaneously, so operand alignment is preserved and products are 0.
- FSM:
  - IDLE: in_rdy_o=0.
    - start_i with 1 <= k_len_i <= K_MAX: latch k_len_i, go to CLEAR.
    - start_i with k_len_i = 0 or k_len_i > K_MAX: err_o=1 for the next cycle, stay in IDLE.
  - CLEAR (1 cycle): clear_o=1, in_rdy_o=0; go to FEED.
  - FEED: in_rdy_o=1.
    - Each handshake increments the beat counter.
    - On the handshake that makes beat count = k_len, load drain counter = ARRAY_HEIGHT+ARRAY_WIDTH+PE_LAT-3 and go to DRAIN.
    - If that value is 0, go straight to DONE.
    - in_rdy_o drops in the cycle after the last beat; no extra beat is ever accepted.
  - DRAIN: in_rdy_o=0; zeros are injected; the drain counter decrements each cycle; at 0, go to DONE.
  - DONE (1 cycle): done_o=1; go to IDLE. The cycle DONE is entered is t_last+H+W+PE_LAT-1, where t_last is the edge of the last beat (t_last+8 for 4x4 with PE_LAT=1).
- start_i is ignored when busy_o=1.
- k_len is held constant for the whole job.
- After done_o, the array results hold their values because the feeder keeps feeding zeros until the next CLEAR.
- Back-to-back jobs: start_i may be asserted in the DONE cycle; it is sampled in the following IDLE cycle.

Test Plan:
- 4x4, K=4, A=identity, B[k][j]=10k+j, in_vld_i held high -> clear_o at the cycle after start; in_rdy_o high exactly 4 cycles; done_o 8 cycles after the last beat; result[i][j]=10i+j.
- Same job with in_vld_i low on beats 2 and 3 for 2 cycles each -> identical results; done_o timing measured from the last accepted beat; zeros observed on active_o/weight_o during the bubbles.
- K=1, A[i]=i+1, B[j]=2 -> result[i][j]=2(i+1); active_o[3] is nonzero only in cycle t+4.
- start_i with k_len_i=0, then k_len_i=K_MAX+1 -> err_o pulses each time, busy_o stays 0, no clear_o.
- Assert rst_i during FEED after 2 beats -> all outputs 0 immediately; a subsequent K=4 job gives correct results.
- start_i asserted during DRAIN -> ignored; the DONE-cycle start_i begins the next job, producing clear_o exactly two cycles after DONE.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Operand beat bus between the job source and the systolic feeder.
// One beat carries a full activation column and a full weight row.
interface systolic_feeder_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ARRAY_WIDTH  = 4,
  parameter int ARRAY_HEIGHT = 4
);
  logic                                     in_vld_i;
  logic                                     in_rdy_o;
  logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0]  act_col_i;
  logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]   wgt_row_i;

  modport master (
    output in_vld_i,
    output act_col_i,
    output wgt_row_i,
    input  in_rdy_o
  );

  modport slave (
    input  in_vld_i,
    input  act_col_i,
    input  wgt_row_i,
    output in_rdy_o
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for the output-stationary systolic array: accepts K-slices,
// skews them diagonally (row i / column j delayed by i / j cycles), clears the
// array at job start, zero-fills bubbles and the drain, and pulses done_o
// once every PE accumulator holds its final dot product.
module systolic_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ARRAY_WIDTH  = 4,
  parameter int ARRAY_HEIGHT = 4,
  parameter int K_MAX        = 64,
  parameter int K_WIDTH      = $clog2(K_MAX + 1),
  parameter int PE_LAT       = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    start_i,
  input  logic [K_WIDTH-1:0]                      k_len_i,
  output logic                                    busy_o,
  output logic                                    err_o,
  systolic_feeder_if.slave                        feed,
  output logic                                    clear_o,
  output logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0] active_o,
  output logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]  weight_o,
  output logic                                    done_o
);

  // Cycles spent in DRAIN after the last beat so the farthest PE sees it.
  localparam int DRAIN_CYC = ARRAY_HEIGHT + ARRAY_WIDTH + PE_LAT - 3;
  localparam int DRAIN_W   = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [K_WIDTH-1:0]   r_klen;
  logic [K_WIDTH-1:0]   r_beat;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 r_in_rdy;
  logic                 r_clear;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 w_fire;
  logic                 w_klen_ok;
  logic [K_WIDTH-1:0]   w_beat_nxt;

  assign w_fire     = feed.in_vld_i && r_in_rdy;
  assign w_klen_ok  = (k_len_i != '0) && (k_len_i <= K_WIDTH'(K_MAX));
  assign w_beat_nxt = r_beat + K_WIDTH'(1);

  assign feed.in_rdy_o = r_in_rdy;
  assign clear_o       = r_clear;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;

  // Job sequencing FSM with registered control outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_klen   <= '0;
      r_beat   <= '0;
      r_drain  <= '0;
      r_in_rdy <= 1'b0;
      r_clear  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_klen_ok) begin
              r_klen  <= k_len_i;
              r_beat  <= '0;
              r_state <= S_CLEAR;
              r_clear <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state  <= S_FEED;
          r_in_rdy <= 1'b1;
        end
        S_FEED: begin
          if (w_fire) begin
            r_beat <= w_beat_nxt;
            // Ready drops at the final handshake edge, so no extra beat can land.
            if (w_beat_nxt == r_klen) begin
              r_in_rdy <= 1'b0;
              if (DRAIN_CYC == 0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_DRAIN;
                r_drain <= DRAIN_W'(DRAIN_CYC);
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_in_rdy <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Activation lanes: lane i is a chain of depth i+1, zero-filled when no beat.
  for (genvar gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_act
    logic [DATA_WIDTH-1:0] r_sr [0:gi];

    // Shift activation lane every cycle; head takes the beat or zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned s = 0; s <= gi; s++) r_sr[s] <= '0;
      end else begin
        r_sr[0] <= w_fire ? feed.act_col_i[gi] : '0;
        for (int unsigned s = 1; s <= gi; s++) r_sr[s] <= r_sr[s-1];
      end
    end

    assign active_o[gi] = r_sr[gi];
  end

  // Weight lanes: lane j is a chain of depth j+1, zero-filled when no beat.
  for (genvar gj = 0; gj < ARRAY_WIDTH; gj++) begin : g_wgt
    logic [DATA_WIDTH-1:0] r_sr [0:gj];

    // Shift weight lane every cycle; head takes the beat or zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned s = 0; s <= gj; s++) r_sr[s] <= '0;
      end else begin
        r_sr[0] <= w_fire ? feed.wgt_row_i[gj] : '0;
        for (int unsigned s = 1; s <= gj; s++) r_sr[s] <= r_sr[s-1];
      end
    end

    assign weight_o[gj] = r_sr[gj];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: per-cycle skew model, array-level
// dot-product model, table-driven illegal starts, and hand-built corner jobs.
module tb_systolic_feeder;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int AH = 4;
  localparam int KM = 64;
  localparam int KW = $clog2(KM + 1);
  localparam int NH = 16384;

  typedef logic [AH-1:0][DW-1:0] act_t;
  typedef logic [AW-1:0][DW-1:0] wgt_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [KW-1:0] k_len_i;
  logic          busy_o, err_o, clear_o, done_o;
  act_t          active_o;
  wgt_t          weight_o;

  systolic_feeder_if #(.DATA_WIDTH(DW), .ARRAY_WIDTH(AW), .ARRAY_HEIGHT(AH)) feed_if ();

  systolic_feeder #(
    .DATA_WIDTH(DW), .ARRAY_WIDTH(AW), .ARRAY_HEIGHT(AH), .K_MAX(KM), .PE_LAT(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .err_o(err_o), .feed(feed_if.slave), .clear_o(clear_o),
    .active_o(active_o), .weight_o(weight_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;     // index of the most recent rising edge
  int   n_acc  = 0;     // beats accepted in the current job
  int   t_last = 0;     // edge of the most recent accepted beat
  int   clr_edge = 0;   // edge at which clear_o went high
  act_t hist_a [0:NH-1];  // beat accepted at edge e (zero when none)
  wgt_t hist_w [0:NH-1];
  act_t obs_a  [0:NH-1];  // DUT outputs just after edge e
  wgt_t obs_w  [0:NH-1];
  act_t ja [0:KM];        // job activation beats
  wgt_t jb [0:KM];        // job weight beats

  typedef struct {
    logic [KW-1:0] k;
    logic          exp_err;
    logic          exp_busy;
    logic          exp_clear;
  } evec_t;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, cyc);
  endtask

  // Advance one edge; record handshakes and compare the skewed outputs against
  // "element accepted at edge t is on lane i right after edge t+i".
  task automatic tick();
    logic f;
    act_t ain, ea;
    wgt_t win, ew;
    f   = feed_if.in_vld_i && feed_if.in_rdy_o;
    ain = feed_if.act_col_i;
    win = feed_if.wgt_row_i;
    @(posedge clk_i);
    cyc++;
    hist_a[cyc] = f ? ain : '0;
    hist_w[cyc] = f ? win : '0;
    if (f) begin
      n_acc++;
      t_last = cyc;
    end
    #1;
    obs_a[cyc] = active_o;
    obs_w[cyc] = weight_o;
    for (int i = 0; i < AH; i++) ea[i] = (cyc >= i) ? hist_a[cyc-i][i] : '0;
    for (int j = 0; j < AW; j++) ew[j] = (cyc >= j) ? hist_w[cyc-j][j] : '0;
    chk("skew_act", active_o, ea);
    chk("skew_wgt", weight_o, ew);
  endtask

  task automatic do_start(input int k);
    start_i = 1'b1;
    k_len_i = KW'(k);
    tick();
    start_i = 1'b0;
    chk("clear_after_start", clear_o, 1);
    chk("busy_after_start", busy_o, 1);
    clr_edge = cyc;
    n_acc = 0;
  endtask

  task automatic drive_beat(input bit vld);
    feed_if.in_vld_i = vld;
    if (vld) begin
      feed_if.act_col_i = ja[n_acc];
      feed_if.wgt_row_i = jb[n_acc];
    end else begin
      for (int i = 0; i < AH; i++) feed_if.act_col_i[i] = $urandom;
      for (int j = 0; j < AW; j++) feed_if.wgt_row_i[j] = $urandom;
    end
  endtask

  // mode 0: valid always high; 1: two-cycle bubbles before beats 2 and 3;
  // 2: random bubbles. poke: hold start_i (k_len k2) from early DRAIN on.
  task automatic feed_finish(input int k, input int mode, input bit poke, input int k2);
    int rdy_cnt, budget, w;
    int gap [0:2];
    bit vld;
    logic [DW-1:0] acc, ex, av, wv;
    rdy_cnt = 0;
    budget = 0;
    gap = '{0, 0, 0};
    while (n_acc < k && budget < 2000) begin
      vld = 1'b1;
      if (mode == 1 && (n_acc == 1 || n_acc == 2) && gap[n_acc] < 2) begin
        vld = 1'b0;
        gap[n_acc]++;
      end else if (mode == 2) begin
        vld = ($urandom_range(0, 3) != 0);
      end
      drive_beat(vld);
      if (feed_if.in_rdy_o) rdy_cnt++;
      tick();
      budget++;
    end
    chk("feed_complete", n_acc, k);
    chk("rdy_drop", feed_if.in_rdy_o, 0);
    if (mode == 0) chk("rdy_cycles", rdy_cnt, k);
    if (mode == 1) chk("rdy_cycles_gapped", rdy_cnt, k + 4);
    // Keep offering junk during drain; nothing more may be accepted.
    w = 0;
    while (!done_o && w < 200) begin
      drive_beat(1'b0);
      feed_if.in_vld_i = 1'b1;
      if (poke && w == 1) begin
        start_i = 1'b1;
        k_len_i = KW'(k2);
      end
      tick();
      w++;
      if (poke && !done_o) chk("drain_start_ignored", {busy_o, clear_o}, 2'b10);
    end
    feed_if.in_vld_i = 1'b0;
    chk("done_seen", done_o, 1);
    // DONE visible right after edge t_last+7, i.e. cycle t_last+8.
    chk("done_time", cyc - t_last, 7);
    chk("busy_at_done", busy_o, 1);
    // Array model: PE(i,j) sees active_o[i] delayed j and weight_o[j] delayed
    // i; products reach the accumulator one cycle later.
    for (int i = 0; i < AH; i++) begin
      for (int j = 0; j < AW; j++) begin
        acc = '0;
        for (int e = clr_edge; e <= cyc - 1; e++) begin
          av = (e - j >= clr_edge) ? obs_a[e-j][i] : '0;
          wv = (e - i >= clr_edge) ? obs_w[e-i][j] : '0;
          acc += av * wv;
        end
        ex = '0;
        for (int n = 0; n < k; n++) ex += ja[n][i] * jb[n][j];
        chk($sformatf("result_%0d_%0d", i, j), acc, ex);
      end
    end
    if (!poke) begin
      tick();
      chk("done_pulse_end", {done_o, busy_o, clear_o}, 3'b000);
    end
  endtask

  task automatic fill_identity();
    for (int n = 0; n <= KM; n++) begin
      for (int i = 0; i < AH; i++) ja[n][i] = (n == i) ? 32'd1 : 32'd0;
      for (int j = 0; j < AW; j++) jb[n][j] = 10 * n + j;
    end
    for (int i = 0; i < AH; i++) ja[4][i] = 32'hDEAD_0000 + i;  // junk past K
  endtask

  task automatic fill_random();
    for (int n = 0; n <= KM; n++) begin
      for (int i = 0; i < AH; i++) ja[n][i] = $urandom;
      for (int j = 0; j < AW; j++) jb[n][j] = $urandom;
    end
  endtask

  initial begin
    evec_t evecs [4];
    int kr;
    evecs[0] = '{k: KW'(0),      exp_err: 1'b1, exp_busy: 1'b0, exp_clear: 1'b0};
    evecs[1] = '{k: KW'(KM + 1), exp_err: 1'b1, exp_busy: 1'b0, exp_clear: 1'b0};
    evecs[2] = '{k: KW'(100),    exp_err: 1'b1, exp_busy: 1'b0, exp_clear: 1'b0};
    evecs[3] = '{k: KW'(127),    exp_err: 1'b1, exp_busy: 1'b0, exp_clear: 1'b0};

    for (int e = 0; e < NH; e++) begin
      hist_a[e] = '0; hist_w[e] = '0; obs_a[e] = '0; obs_w[e] = '0;
    end
    rst_i = 1'b1;
    start_i = 1'b0;
    k_len_i = '0;
    feed_if.in_vld_i = 1'b0;
    feed_if.act_col_i = '0;
    feed_if.wgt_row_i = '0;
    #1;
    chk("reset_state", {busy_o, err_o, clear_o, done_o, feed_if.in_rdy_o, active_o, weight_o}, '0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // Illegal k_len: err pulse for one cycle, no job.
    for (int v = 0; v < 4; v++) begin
      start_i = 1'b1;
      k_len_i = evecs[v].k;
      tick();
      start_i = 1'b0;
      chk("err_pulse", err_o, evecs[v].exp_err);
      chk("err_busy", busy_o, evecs[v].exp_busy);
      chk("err_clear", clear_o, evecs[v].exp_clear);
      tick();
      chk("err_one_cycle", {err_o, busy_o, clear_o}, 3'b000);
    end

    // Identity A, B[k][j]=10k+j, valid held high.
    fill_identity();
    do_start(4);
    feed_finish(4, 0, 1'b0, 0);

    // Same job with bubbles before beats 2 and 3.
    do_start(4);
    feed_finish(4, 1, 1'b0, 0);

    // K=1: last activation lane carries its element only right after t+3.
    for (int i = 0; i < AH; i++) ja[0][i] = i + 1;
    for (int j = 0; j < AW; j++) jb[0][j] = 2;
    do_start(1);
    feed_finish(1, 0, 1'b0, 0);
    chk("k1_lane3_before", obs_a[t_last+2][3], 0);
    chk("k1_lane3_at", obs_a[t_last+3][3], 4);
    chk("k1_lane3_after", obs_a[t_last+4][3], 0);

    // Reset after two beats abandons the job.
    fill_identity();
    do_start(4);
    begin : two_beats
      int b;
      b = 0;
      while (n_acc < 2 && b < 20) begin
        drive_beat(1'b1);
        tick();
        b++;
      end
    end
    chk("pre_reset_beats", n_acc, 2);
    #2;
    rst_i = 1'b1;
    feed_if.in_vld_i = 1'b0;
    #1;
    chk("reset_mid_job", {busy_o, err_o, clear_o, done_o, feed_if.in_rdy_o, active_o, weight_o}, '0);
    for (int e = cyc - 8; e <= cyc; e++) if (e >= 0) begin hist_a[e] = '0; hist_w[e] = '0; end
    tick();
    rst_i = 1'b0;
    tick();
    chk("no_done_after_reset", {done_o, busy_o}, 2'b00);
    do_start(4);
    feed_finish(4, 0, 1'b0, 0);

    // start_i during DRAIN ignored; start held in DONE begins the next job.
    fill_random();
    do_start(5);
    feed_finish(5, 0, 1'b1, 3);
    tick();
    chk("b2b_idle", {clear_o, done_o, busy_o}, 3'b000);
    tick();
    start_i = 1'b0;
    chk("b2b_clear", clear_o, 1);
    clr_edge = cyc;
    n_acc = 0;
    fill_random();
    feed_finish(3, 2, 1'b0, 0);

    // Randomised jobs, including maximum length.
    for (int r = 0; r < 6; r++) begin
      kr = (r == 5) ? KM : $urandom_range(1, 12);
      fill_random();
      do_start(kr);
      feed_finish(kr, (r % 2 == 0) ? 2 : 0, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
